pdu_buf_ctrl: RTL and testbench

PDU_BUF_CTRL -- requirements
Module: pdu_buf_ctrl

---
 rtl/pdu_buf_pkg.sv | 16 +
 rtl/pdu_buf_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pdu_buf_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdu_buf_pkg.sv
// pdu_buf_pkg
//   Shared definitions for the PDU buffer controller: state encoding and
//   default widths used as parameter defaults by pdu_buf_ctrl.
package pdu_buf_pkg;

    localparam int PDU_BUF_DATA_WIDTH_DEF = 8;
    localparam int PDU_BUF_ADDR_WIDTH_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_OUT     = 2'd3
    } pdu_buf_state_e;

endpackage

// File: rtl/pdu_buf_ctrl.sv
// pdu_buf_ctrl
//   Store-and-forward controller for one PDU held in an external dual-port
//   RAM (1-cycle read latency). A frame of frame_len words is written from a
//   serial stream, then drained on a valid/ready stream at up to one word
//   every two cycles.
//
//   Optional feature: define PDU_BUF_ABORT_EN to add the abort input, which
//   drops the frame in progress from any non-IDLE state.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   frame_start, frame_len      start pulse and word count (1..2^ADDRESS_WIDTH)
//   data_in, data_in_valid      write stream, no backpressure
//   abort                       drop current frame (PDU_BUF_ABORT_EN only)
//   ram_wr_en/addr/data         RAM write port
//   ram_rd_addr, ram_rd_data    RAM read port
//   out_data/valid/last, out_ready  drain stream
//   busy                        high whenever not IDLE
//   len_err, drop               one-cycle error pulses
//
// State     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for frame_start
// ST_FILL   | writing incoming words at wr_ptr until len words stored
// ST_RD_WAIT| rd_ptr presented to RAM, waiting out the read latency
// ST_OUT    | RAM data on out_data, waiting for the handshake
module pdu_buf_ctrl
    import pdu_buf_pkg::*;
#(
    parameter int DATA_WIDTH    = PDU_BUF_DATA_WIDTH_DEF,
    parameter int ADDRESS_WIDTH = PDU_BUF_ADDR_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic [ADDRESS_WIDTH:0]   frame_len,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     data_in_valid,
`ifdef PDU_BUF_ABORT_EN
    input  logic                     abort,
`endif
    output logic                     ram_wr_en,
    output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0]    ram_wr_data,
    output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]    ram_rd_data,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     len_err,
    output logic                     drop
);

    // Pointers and length carry one extra bit so a full-depth length
    // (2^ADDRESS_WIDTH) is representable and len-1 never underflows.
    localparam logic [ADDRESS_WIDTH:0] DEPTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [ADDRESS_WIDTH:0] ONE   = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

    pdu_buf_state_e          state_q, state_d;
    logic [ADDRESS_WIDTH:0]  len_q, len_d;
    logic [ADDRESS_WIDTH:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH:0]  rd_ptr_q, rd_ptr_d;
    logic                    len_err_q, len_err_d;
    logic                    drop_q, drop_d;

    logic abort_hit;
    logic len_ok;
    logic wr_last;
    logic rd_last;
    logic fill_wr;
    logic out_vld;
    logic handshake;

`ifdef PDU_BUF_ABORT_EN
    assign abort_hit = abort && (state_q != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        len_ok    = (frame_len != '0) && (frame_len <= DEPTH);
        wr_last   = (wr_ptr_q == (len_q - ONE));
        rd_last   = (rd_ptr_q == (len_q - ONE));
        // Abort wins over a same-cycle write or handshake by masking both.
        fill_wr   = (state_q == ST_FILL) && data_in_valid && !abort_hit;
        out_vld   = (state_q == ST_OUT) && !abort_hit;
        handshake = out_vld && out_ready;
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        len_err_d = 1'b0;
        drop_d    = (data_in_valid && (state_q != ST_FILL))
                 || (frame_start && (state_q != ST_IDLE))
                 || abort_hit;

        if (abort_hit) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        if (len_ok) begin
                            len_d    = frame_len;
                            wr_ptr_d = '0;
                            state_d  = ST_FILL;
                        end else begin
                            len_err_d = 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (data_in_valid) begin
                        if (wr_last) begin
                            rd_ptr_d = '0;
                            state_d  = ST_RD_WAIT;
                        end else begin
                            wr_ptr_d = wr_ptr_q + ONE;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    state_d = ST_OUT;
                end
                ST_OUT: begin
                    if (handshake) begin
                        if (rd_last) begin
                            state_d = ST_IDLE;
                        end else begin
                            rd_ptr_d = rd_ptr_q + ONE;
                            state_d  = ST_RD_WAIT;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            len_err_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            len_err_q <= len_err_d;
            drop_q    <= drop_d;
        end
    end

    // Addresses and data are forced to zero outside their active states so
    // the ports read as zero while reset holds the FSM in IDLE.
    assign ram_wr_en   = fill_wr;
    assign ram_wr_addr = (state_q == ST_FILL) ? wr_ptr_q[ADDRESS_WIDTH-1:0] : '0;
    assign ram_wr_data = (state_q == ST_FILL) ? data_in : '0;
    assign ram_rd_addr = ((state_q == ST_RD_WAIT) || (state_q == ST_OUT))
                         ? rd_ptr_q[ADDRESS_WIDTH-1:0] : '0;
    assign out_valid   = out_vld;
    assign out_data    = out_vld ? ram_rd_data : '0;
    assign out_last    = out_vld && rd_last;
    assign busy        = (state_q != ST_IDLE);
    assign len_err     = len_err_q;
    assign drop        = drop_q;

endmodule

// File: tb/tb_pdu_buf_ctrl.sv
// tb_pdu_buf_ctrl
//   Self-checking bench for pdu_buf_ctrl with a behavioural RAM. Each frame's
//   expected writes and drained words come from the frame contents the bench
//   generated; a negedge monitor records what the DUT actually did.
//   Build with +define+PDU_BUF_ABORT_EN to also exercise abort.
module tb_pdu_buf_ctrl;
    import pdu_buf_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int BUDGET = 4000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic [AW:0]   frame_len = '0;
    logic [DW-1:0] data_in = '0;
    logic          data_in_valid = 1'b0;
    logic          abort_drv = 1'b0;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          len_err;
    logic          drop;

    logic [DW-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    pdu_buf_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .frame_len     (frame_len),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
`ifdef PDU_BUF_ABORT_EN
        .abort         (abort_drv),
`endif
        .ram_wr_en     (ram_wr_en),
        .ram_wr_addr   (ram_wr_addr),
        .ram_wr_data   (ram_wr_data),
        .ram_rd_addr   (ram_rd_addr),
        .ram_rd_data   (ram_rd_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .out_ready     (out_ready),
        .busy          (busy),
        .len_err       (len_err),
        .drop          (drop)
    );

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    // Monitor: only this process writes these.
    int   wr_addr_q[$];
    int   wr_data_q[$];
    int   out_data_q[$];
    int   out_last_q[$];
    int   len_err_cyc = 0;
    int   drop_cyc = 0;
    int   stall_viol = 0;
    int   last_cnt = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk) begin
        if (ram_wr_en === 1'b1) begin
            wr_addr_q.push_back(int'(ram_wr_addr));
            wr_data_q.push_back(int'(ram_wr_data));
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            out_data_q.push_back(int'(out_data));
            out_last_q.push_back(int'(out_last));
            if (out_last === 1'b1) last_cnt++;
        end
        if (len_err === 1'b1) len_err_cyc++;
        if (drop === 1'b1) drop_cyc++;
        if (prev_stall && rst_n && !abort_drv &&
            (out_valid !== 1'b1 || out_data !== prev_data || ram_rd_addr !== prev_addr))
            stall_viol++;
        prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
        prev_data  = out_data;
        prev_addr  = ram_rd_addr;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: plain, 1: hold out_ready low 5 cycles on the second word,
    // 2: frame_start and data_in_valid injected during OUT, 3: abort mid-OUT.
    task automatic run_frame(input int len, input int gap_pct, input int stall_pct,
                             input int mode, input int base_val);
        logic [DW-1:0] d[$];
        int sent, cyc, wb, ob, db, lb, sb, stall_left, inj, exp_out, exp_drop;
        bit aborted;
        for (int i = 0; i < len; i++)
            d.push_back(base_val < 0 ? 8'($urandom) : 8'(base_val + i));
        wb = wr_addr_q.size();
        ob = out_data_q.size();
        db = drop_cyc;
        lb = last_cnt;
        sb = stall_viol;

        frame_start = 1'b1;
        frame_len   = len[AW:0];
        tick();
        frame_start = 1'b0;
        chk("busy_after_start", busy, 1);

        sent = 0;
        cyc  = 0;
        while (sent < len && cyc < BUDGET) begin
            if ($urandom_range(99) < gap_pct) begin
                data_in_valid = 1'b0;
            end else begin
                data_in_valid = 1'b1;
                data_in       = d[sent];
                sent++;
            end
            tick();
            cyc++;
        end
        data_in_valid = 1'b0;
        chk("fill_budget", cyc < BUDGET, 1);

        cyc        = 0;
        stall_left = 5;
        inj        = 0;
        aborted    = 0;
        while (last_cnt == lb && !aborted && cyc < BUDGET) begin
            out_ready = ($urandom_range(99) >= stall_pct);
            if (mode == 1 && out_valid && (out_data_q.size() - ob) == 1 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end
            if (mode == 2 && out_valid && inj < 3) begin
                out_ready = 1'b0;
                if (inj == 0) begin
                    frame_start = 1'b1;
                    frame_len   = 7'd2;
                end else if (inj == 1) begin
                    data_in_valid = 1'b1;
                    data_in       = 8'h5A;
                end
                inj++;
            end
            if (mode == 3 && out_valid && (out_data_q.size() - ob) == 1) begin
                abort_drv = 1'b1;
                out_ready = 1'b1;
                aborted   = 1;
            end
            tick();
            cyc++;
            frame_start   = 1'b0;
            data_in_valid = 1'b0;
            abort_drv     = 1'b0;
        end
        chk("drain_budget", cyc < BUDGET, 1);
        if (mode == 0 && stall_pct == 0) chk("drain_cycles", cyc, 2 * len);
        chk("busy_end", busy, 0);
        out_ready = 1'b0;
        tick();

        chk("wr_count", wr_addr_q.size() - wb, len);
        for (int i = 0; i < len && (wb + i) < wr_addr_q.size(); i++) begin
            chk("wr_addr", wr_addr_q[wb + i], i);
            chk("wr_data", wr_data_q[wb + i], d[i]);
        end
        exp_out = (mode == 3) ? 1 : len;
        chk("out_count", out_data_q.size() - ob, exp_out);
        for (int i = 0; i < exp_out && (ob + i) < out_data_q.size(); i++) begin
            chk("out_data", out_data_q[ob + i], d[i]);
            chk("out_last", out_last_q[ob + i], (i == len - 1) ? 1 : 0);
        end
        exp_drop = (mode == 2) ? 2 : ((mode == 3) ? 1 : 0);
        chk("drop_pulses", drop_cyc - db, exp_drop);
        chk("stall_hold", stall_viol - sb, 0);
        if (mode == 1) chk("stall_applied", stall_left, 0);
    endtask

    initial begin
        int wb, lb, db, len;

        // Reset with hostile inputs: everything must read zero.
        frame_start   = 1'b1;
        frame_len     = 7'd4;
        data_in_valid = 1'b1;
        data_in       = 8'hFF;
        out_ready     = 1'b1;
        #22;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_ram_wr_en", ram_wr_en, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_drop", drop, 0);
        chk("rst_wr_addr", ram_wr_addr, 0);
        chk("rst_rd_addr", ram_rd_addr, 0);
        chk("rst_out_data", out_data, 0);
        frame_start   = 1'b0;
        data_in_valid = 1'b0;
        out_ready     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // Back-to-back A1..A4 with out_ready held high.
        run_frame(4, 0, 0, 0, 'hA1);

        // Full depth with gaps and backpressure.
        run_frame(DEPTH, 30, 30, 0, -1);

        // Illegal lengths.
        wb = wr_addr_q.size();
        lb = len_err_cyc;
        frame_start = 1'b1;
        frame_len   = 7'd0;
        tick();
        frame_start = 1'b0;
        chk("len0_err_now", len_err, 1);
        chk("len0_busy", busy, 0);
        tick();
        chk("len0_err_clear", len_err, 0);
        frame_start = 1'b1;
        frame_len   = 7'd65;
        tick();
        frame_start = 1'b0;
        chk("len65_err_now", len_err, 1);
        chk("len65_busy", busy, 0);
        tick();
        len = $urandom_range(127, 66);
        frame_start = 1'b1;
        frame_len   = len[AW:0];
        tick();
        frame_start = 1'b0;
        chk("lenbig_busy", busy, 0);
        tick();
        chk("len_err_pulses", len_err_cyc - lb, 3);
        chk("len_err_no_writes", wr_addr_q.size() - wb, 0);

        // Stray data in IDLE is dropped.
        db = drop_cyc;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        chk("idle_data_drop", drop, 1);
        tick();
        chk("idle_data_drop_clear", drop, 0);
        chk("idle_data_drop_cnt", drop_cyc - db, 1);

        // Backpressure hold and intrusions during OUT.
        run_frame(3, 0, 0, 1, -1);
        run_frame(3, 0, 0, 2, -1);

        // Reset mid-FILL after 2 of 5 words.
        wb = wr_addr_q.size();
        frame_start = 1'b1;
        frame_len   = 7'd5;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_in_valid = 1'b1;
            data_in       = 8'h10 + 8'(i);
            tick();
        end
        data_in       = 8'h77;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_wr_en", ram_wr_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        data_in_valid = 1'b0;
        chk("midrst_idle", busy, 0);
        tick();
        chk("midrst_writes", wr_addr_q.size() - wb, 2);
        run_frame(2, 0, 0, 0, -1);

`ifdef PDU_BUF_ABORT_EN
        run_frame(4, 0, 0, 3, -1);
`endif

        // Random frames, including the length boundaries.
        for (int k = 0; k < 8; k++) begin
            if (k == 0)      len = 1;
            else if (k == 1) len = DEPTH;
            else             len = $urandom_range(DEPTH, 1);
            run_frame(len, $urandom_range(50), $urandom_range(60), 0, -1);
        end
        run_frame(5, 0, 0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
